seq_tx: RTL and testbench

//   Serial bit-stream transmitter; the sending end of the single-bit serial

---
 rtl/seq_tx.sv | 129 ++++++++++++
 tb/tb_seq_tx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seq_tx.sv
// Serial bit-stream transmitter: shifts a latched pattern out MSB-first on `a`,
// replaying it in_rep+1 times with GAP_CYCLES idle cycles between passes.
module seq_tx #(
    parameter int   WIDTH      = 8,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_BIT   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH+1)-1:0] in_len,
    input  logic [3:0]                 in_rep,
    input  logic                       abort,
    output logic                       a,
    output logic                       a_valid,
    output logic                       busy,
    output logic                       done
);
    localparam int LW = $clog2(WIDTH+1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] pat;   // pattern left-aligned so bit len-1 sits at the MSB
        logic [LW-1:0]    len;
    } req_t;

    state_t           state, state_n;
    req_t             req, req_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [LW-1:0]    bleft, bleft_n;
    logic [3:0]       rep_left, rep_n;
    logic [GW-1:0]    gcnt, gcnt_n;
    logic             a_n, av_n, busy_n, done_n;
    logic [LW-1:0]    len_eff;
    logic [WIDTH-1:0] aligned;

    assign in_ready = (state == IDLE) && !abort;
    assign len_eff  = (in_len == '0 || in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
    assign aligned  = in_data << (LW'(WIDTH) - len_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            req      <= '0;
            shreg    <= '0;
            bleft    <= '0;
            rep_left <= '0;
            gcnt     <= '0;
            a        <= IDLE_BIT;
            a_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            req      <= req_n;
            shreg    <= shreg_n;
            bleft    <= bleft_n;
            rep_left <= rep_n;
            gcnt     <= gcnt_n;
            a        <= a_n;
            a_valid  <= av_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        req_n   = req;
        shreg_n = shreg;
        bleft_n = bleft;
        rep_n   = rep_left;
        gcnt_n  = gcnt;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state_n   = SHIFT;
                    req_n.pat = aligned;
                    req_n.len = len_eff;
                    shreg_n   = aligned;
                    bleft_n   = len_eff - 1'b1;
                    rep_n     = in_rep;
                end
                SHIFT: begin
                    if (bleft != '0) begin
                        shreg_n = shreg << 1;
                        bleft_n = bleft - 1'b1;
                    end else if (rep_left != '0) begin
                        rep_n = rep_left - 1'b1;
                        if (GAP_CYCLES > 0) begin
                            state_n = GAP;
                            gcnt_n  = GW'(GAP_CYCLES - 1);
                        end else begin
                            // no gap: next pass starts without a bubble
                            shreg_n = req.pat;
                            bleft_n = req.len - 1'b1;
                        end
                    end else begin
                        state_n = IDLE;
                    end
                end
                GAP: begin
                    if (gcnt == '0) begin
                        state_n = SHIFT;
                        shreg_n = req.pat;
                        bleft_n = req.len - 1'b1;
                    end else begin
                        gcnt_n = gcnt - 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // outputs are registered: derive next-cycle values from the next state
    always_comb begin
        av_n   = (state_n == SHIFT);
        busy_n = (state_n != IDLE);
        a_n    = av_n ? shreg_n[WIDTH-1] : IDLE_BIT;
        done_n = !abort && (state == SHIFT) && (state_n == IDLE);
    end
endmodule

// File: tb/tb_seq_tx.sv
// Randomized bench for seq_tx: a queue-based model expands each accepted request
// into its expected per-cycle output stream.
module tb_seq_tx;
    localparam int   WIDTH      = 8;
    localparam int   GAP_CYCLES = 2;
    localparam logic IDLE_BIT   = 1'b0;

    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, abort = 1'b0;
    logic [7:0] in_data = '0;
    logic [3:0] in_len = '0, in_rep = '0;
    logic       in_ready, a, a_valid, busy, done;

    seq_tx #(.WIDTH(WIDTH), .GAP_CYCLES(GAP_CYCLES), .IDLE_BIT(IDLE_BIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .in_rep(in_rep), .abort(abort),
        .a(a), .a_valid(a_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic a; logic av; logic busy; logic done;} out_t;

    int   n_tests = 0, n_fail = 0;
    out_t cur = '0;
    out_t exp_q[$];
    logic [7:0] rx;
    int   busy_cnt, done_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // expand one request into the cycle-by-cycle outputs that follow acceptance
    task automatic build(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        int le;
        le = (l == 0 || l > WIDTH) ? WIDTH : int'(l);
        for (int p = 0; p <= int'(r); p++) begin
            for (int i = le - 1; i >= 0; i--) exp_q.push_back({d[i], 1'b1, 1'b1, 1'b0});
            if (p < int'(r))
                for (int g = 0; g < GAP_CYCLES; g++) exp_q.push_back({IDLE_BIT, 1'b0, 1'b1, 1'b0});
        end
        exp_q.push_back({IDLE_BIT, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic [3:0] l,
                        input logic [3:0] r, input logic ab);
        logic acc;
        in_valid = v; in_data = d; in_len = l; in_rep = r; abort = ab;
        #1;
        check("in_ready", in_ready, !cur.busy && !ab);
        acc = v && !cur.busy && !ab;
        @(posedge clk);
        if (ab) begin
            exp_q.delete();
            cur = '0;
        end else begin
            if (acc) build(d, l, r);
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : out_t'(4'b0);
        end
        @(negedge clk);
        check("a", a, cur.a);
        check("a_valid", a_valid, cur.av);
        check("busy", busy, cur.busy);
        check("done", done, cur.done);
        if (a_valid) rx = {rx[6:0], a};
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_a", a, IDLE_BIT);
        check("rst_a_valid", a_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1'b1);

        // single 8-bit pass
        rx = '0; done_cnt = 0;
        step(1'b1, 8'b1011_0010, 4'd8, 4'd0, 1'b0);
        idle(9);
        check("single_rx", rx, 8'hB2);
        check("single_done_cnt", done_cnt, 1);

        // repeat with gap: 3+2+3+2+3 busy cycles
        busy_cnt = 0; done_cnt = 0;
        step(1'b1, 8'b101, 4'd3, 4'd2, 1'b0);
        idle(14);
        check("gap_busy_cnt", busy_cnt, 13);
        check("gap_done_cnt", done_cnt, 1);

        // length edges, then in_valid held high for back-to-back transfers
        step(1'b1, 8'h01, 4'd1, 4'd0, 1'b0);
        idle(3);
        for (int i = 0; i < 22; i++) step(1'b1, 8'hC5, 4'd0, 4'd0, 1'b0);
        idle(3);

        // abort on the 4th bit, then abort with in_valid while idle
        step(1'b1, 8'hA7, 4'd8, 4'd0, 1'b0);
        idle(3);
        step(1'b1, 8'h00, 4'd0, 4'd0, 1'b1);
        idle(2);
        step(1'b1, 8'hFF, 4'd8, 4'd0, 1'b1);
        check("abort_idle_busy", busy, 1'b0);
        idle(2);

        // async reset mid-pass
        step(1'b1, 8'hFF, 4'd8, 4'd1, 1'b0);
        idle(3);
        #2 rst = 1'b1;
        #1;
        check("arst_a_valid", a_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        exp_q.delete();
        cur = '0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            logic       v, ab;
            logic [7:0] d;
            logic [3:0] l, r;
            v  = ($urandom_range(0, 3) == 0);
            d  = 8'($urandom);
            l  = 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            ab = ($urandom_range(0, 60) == 0);
            step(v, d, l, r, ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
